// File: rtl/jesd204b_rx_lane_sync.sv
// rtl/jesd204b_rx_lane_sync.sv - per-lane JESD204B receive CGS/ILAS synchronizer
//
// Consumes 4-octet comma-aligned 8b/10b-decoded words. It runs code group
// sync, drives SYNC~, walks the 4-multiframe ILAS capturing the link
// configuration, and then passes user data with a valid flag.
//
// Ports:
//   i_clk, i_rst_n        lane parallel clock, synchronous active-low reset
//   i_data[31:0]          decoded octets, octet 0 = i_data[7:0] is earliest
//   i_charisk[3:0]        per-octet K-character flag
//   i_disperr[3:0]        per-octet disparity error
//   i_notintable[3:0]     per-octet invalid code group
//   i_lmfc_edge           single-cycle LMFC boundary pulse
//   o_nsync               SYNC~ to the transmitter, 0 = request sync
//   o_data, o_charisk     input word and K flags delayed by one cycle
//   o_data_valid          high while the lane is in DATA
//   o_ila_cfg[111:0]      ILAS config octets 0..13, octet n = bits [8n+7:8n]
//   o_ila_cfg_valid       config capture complete
//   o_ilas_err            one-cycle pulse on an ILAS sequence violation
//   o_state[2:0]          FSM state encoding
//   o_resync_cnt[7:0]     saturating count of DATA -> CGS_WAIT drops

module jesd204b_rx_lane_sync #(
    parameter int FRAME_SIZE = 1,
    parameter int FMLC_NUM   = 32,
    parameter int CGS_K_CNT  = 4,
    parameter int ERR_THRESH = 3
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [31:0]  i_data,
    input  logic [3:0]   i_charisk,
    input  logic [3:0]   i_disperr,
    input  logic [3:0]   i_notintable,
    input  logic         i_lmfc_edge,
    output logic         o_nsync,
    output logic [31:0]  o_data,
    output logic [3:0]   o_charisk,
    output logic         o_data_valid,
    output logic [111:0] o_ila_cfg,
    output logic         o_ila_cfg_valid,
    output logic         o_ilas_err,
    output logic [2:0]   o_state,
    output logic [7:0]   o_resync_cnt
);

    // Words per multiframe; F*K is a multiple of 4 in 20..1024, so MFW >= 5.
    localparam int MFW  = (FRAME_SIZE * FMLC_NUM) / 4;
    localparam int WC_W = (MFW > 1) ? $clog2(MFW) : 1;
    localparam logic [WC_W-1:0] WC_LAST   = WC_W'(MFW - 1);
    localparam logic [3:0]      KCNT_DONE = 4'(CGS_K_CNT);
    localparam logic [3:0]      ECNT_DONE = 4'(ERR_THRESH);

    typedef enum logic [2:0] {
        ST_CGS_WAIT  = 3'd0,
        ST_CGS_CHECK = 3'd1,
        ST_LMFC_WAIT = 3'd2,
        ST_ILAS_WAIT = 3'd3,
        ST_ILAS      = 3'd4,
        ST_DATA      = 3'd5
    } state_t;

    state_t          state;
    logic [3:0]      kcnt;
    logic [3:0]      ecnt;
    logic [WC_W-1:0] wc;
    logic [1:0]      mc;

    // Word classification
    logic errored;
    logic k_word;
    logic oct0_r;
    logic oct1_q;
    logic oct3_a;
    logic ilas_start;
    logic ilas_viol;
    logic ilas_fault;
    logic ecnt_hit;
    logic drop;

    assign errored = |(i_disperr | i_notintable);
    // An errored word never counts as a K-word, so a corrupted comma breaks CGS.
    assign k_word  = !errored && (i_charisk == 4'hF) && (i_data == 32'hBCBC_BCBC);
    assign oct0_r  = i_charisk[0] && (i_data[7:0]   == 8'h1C);
    assign oct1_q  = i_charisk[1] && (i_data[15:8]  == 8'h9C);
    assign oct3_a  = i_charisk[3] && (i_data[31:24] == 8'h7C);

    assign ilas_start = oct0_r && !errored;

    assign ilas_viol = errored
                    || ((wc == '0) && !oct0_r)
                    || ((wc == WC_LAST) && !oct3_a)
                    || ((mc == 2'd1) && (wc == '0) && !oct1_q);

    assign ilas_fault = ((state == ST_ILAS_WAIT) && !k_word && !ilas_start)
                     || ((state == ST_ILAS) && ilas_viol);

    assign ecnt_hit = ((ecnt + 4'd1) == ECNT_DONE);

    // Every path back to CGS_WAIT from a non-idle state funnels through here.
    assign drop = ilas_fault
               || (((state == ST_CGS_CHECK) || (state == ST_LMFC_WAIT)) && !k_word)
               || ((state == ST_DATA) && errored && ecnt_hit);

    // Config capture: multiframe octet index wc*4+n in 2..15 maps to config
    // octet (index-2). Only MF1 carries the configuration.
    logic [111:0] ila_cfg_next;
    logic [13:0]  cfg_hit;

    genvar j;
    generate
        for (j = 0; j < 14; j++) begin : g_cfg
            localparam int WI = (j + 2) / 4;
            localparam int NI = (j + 2) % 4;
            assign cfg_hit[j] = (mc == 2'd1) && (wc == WC_W'(WI));
            assign ila_cfg_next[j*8 +: 8] = cfg_hit[j] ? i_data[NI*8 +: 8]
                                                       : o_ila_cfg[j*8 +: 8];
        end
    endgenerate

    assign o_state = state;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state           <= ST_CGS_WAIT;
            kcnt            <= 4'd0;
            ecnt            <= 4'd0;
            wc              <= '0;
            mc              <= 2'd0;
            o_nsync         <= 1'b0;
            o_data          <= 32'd0;
            o_charisk       <= 4'd0;
            o_data_valid    <= 1'b0;
            o_ila_cfg       <= 112'd0;
            o_ila_cfg_valid <= 1'b0;
            o_ilas_err      <= 1'b0;
            o_resync_cnt    <= 8'd0;
        end else begin
            o_data     <= i_data;
            o_charisk  <= i_charisk;
            o_ilas_err <= ilas_fault;

            if (drop) begin
                state           <= ST_CGS_WAIT;
                o_nsync         <= 1'b0;
                o_data_valid    <= 1'b0;
                o_ila_cfg_valid <= 1'b0;
                kcnt            <= 4'd0;
                ecnt            <= 4'd0;
                wc              <= '0;
                mc              <= 2'd0;
                // Only a DATA-state loss counts as a resync event.
                if ((state == ST_DATA) && (o_resync_cnt != 8'hFF)) begin
                    o_resync_cnt <= o_resync_cnt + 8'd1;
                end
            end else begin
                case (state)
                    ST_CGS_WAIT: begin
                        o_nsync      <= 1'b0;
                        o_data_valid <= 1'b0;
                        kcnt         <= 4'd0;
                        if (k_word) begin
                            kcnt  <= 4'd1;
                            state <= (KCNT_DONE == 4'd1) ? ST_LMFC_WAIT : ST_CGS_CHECK;
                        end
                    end
                    ST_CGS_CHECK: begin
                        // Non-K words were handled by drop; an LMFC edge here
                        // is deliberately ignored even on the completing word.
                        kcnt <= kcnt + 4'd1;
                        if ((kcnt + 4'd1) == KCNT_DONE) begin
                            state <= ST_LMFC_WAIT;
                        end
                    end
                    ST_LMFC_WAIT: begin
                        if (i_lmfc_edge) begin
                            o_nsync <= 1'b1;
                            state   <= ST_ILAS_WAIT;
                        end
                    end
                    ST_ILAS_WAIT: begin
                        // The /R/ word that ends the comma stream is word 0 of
                        // MF0, so the counter resumes at word 1.
                        if (ilas_start) begin
                            state <= ST_ILAS;
                            wc    <= WC_W'(1);
                            mc    <= 2'd0;
                        end
                    end
                    ST_ILAS: begin
                        o_ila_cfg <= ila_cfg_next;
                        if (cfg_hit[13]) begin
                            o_ila_cfg_valid <= 1'b1;
                        end
                        if (wc == WC_LAST) begin
                            wc <= '0;
                            if (mc == 2'd3) begin
                                state <= ST_DATA;
                            end else begin
                                mc <= mc + 2'd1;
                            end
                        end else begin
                            wc <= wc + WC_W'(1);
                        end
                    end
                    ST_DATA: begin
                        o_data_valid <= 1'b1;
                        ecnt         <= errored ? (ecnt + 4'd1) : 4'd0;
                    end
                    default: begin
                        state <= ST_CGS_WAIT;
                    end
                endcase
            end
        end
    end

endmodule
